poly5_horner_ctrl: RTL and testbench

//  - Evaluates y = c5*x^5 + c4*x^4 + ... + c0 in Horner form on one shared external 16s x 16s -> 32 multiplier.
//  - Top-level sequencer for the Poly5 datapath: owns the ap_* block handshake and drives the multiplier operands.
//  - Rescales each product, adds the next coefficient, and returns a 16-bit fixed-point result.

---
 rtl/poly5_horner_if.sv | 30 +++
 rtl/poly5_horner_ctrl.sv | 143 ++++++++++++++
 tb/tb_poly5_horner_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/poly5_horner_if.sv
// Block handshake, operand and shared-multiplier bus for poly5_horner_ctrl.
interface poly5_horner_if #(
  parameter int DW = 16
);
  logic            ap_start;
  logic            ap_done;
  logic            ap_idle;
  logic            ap_ready;
  logic [DW-1:0]   x;
  logic [DW-1:0]   c0;
  logic [DW-1:0]   c1;
  logic [DW-1:0]   c2;
  logic [DW-1:0]   c3;
  logic [DW-1:0]   c4;
  logic [DW-1:0]   c5;
  logic [DW-1:0]   mul_din0;
  logic [DW-1:0]   mul_din1;
  logic [2*DW-1:0] mul_dout;
  logic [DW-1:0]   ap_return;

  modport master (
    output ap_start, x, c0, c1, c2, c3, c4, c5, mul_dout,
    input  ap_done, ap_idle, ap_ready, mul_din0, mul_din1, ap_return
  );

  modport slave (
    input  ap_start, x, c0, c1, c2, c3, c4, c5, mul_dout,
    output ap_done, ap_idle, ap_ready, mul_din0, mul_din1, ap_return
  );
endinterface

// File: rtl/poly5_horner_ctrl.sv
// Horner-form evaluator of a 5th-order polynomial on one shared external multiplier.
// Define POLY5_HORNER_SAT_EN to saturate each step instead of wrapping.
//
// state  | meaning
// S_IDLE | waiting for ap_start; operands not latched
// S_RUN  | five multiply/accumulate steps, cnt walks 4..0
// S_DONE | ap_done/ap_ready pulse; ap_start here starts the next op at once
module poly5_horner_ctrl #(
  parameter int FRAC_BITS = 8,
  parameter int DW        = 16
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  poly5_horner_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;

  logic signed [DW-1:0]   r_x;
  logic signed [DW-1:0]   r_acc;
  logic signed [DW-1:0]   r_ret;
  logic signed [DW-1:0]   r_c0;
  logic signed [DW-1:0]   r_c1;
  logic signed [DW-1:0]   r_c2;
  logic signed [DW-1:0]   r_c3;
  logic signed [DW-1:0]   r_c4;
  logic [2:0]             r_cnt;

  logic signed [DW-1:0]   w_coef;
  logic signed [DW-1:0]   w_f;
  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW-1:0] w_shift;
  logic signed [2*DW-1:0] w_sum;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    bus.ap_idle  = 1'b0;
    bus.ap_done  = 1'b0;
    bus.ap_ready = 1'b0;
    bus.mul_din0 = '0;
    bus.mul_din1 = '0;
    case (r_state)
      S_IDLE: begin
        bus.ap_idle = 1'b1;
        if (bus.ap_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        bus.mul_din0 = r_acc;
        bus.mul_din1 = r_x;
        if (r_cnt == 3'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.ap_done  = 1'b1;
        bus.ap_ready = 1'b1;
        if (bus.ap_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // c5 seeds the accumulator, so only c0..c4 are selected per step.
  always_comb begin
    case (r_cnt)
      3'd0:    w_coef = r_c0;
      3'd1:    w_coef = r_c1;
      3'd2:    w_coef = r_c2;
      3'd3:    w_coef = r_c3;
      default: w_coef = r_c4;
    endcase
  end

  assign w_prod  = $signed(bus.mul_dout);
  assign w_shift = w_prod >>> FRAC_BITS;
  assign w_sum   = w_shift + {{DW{w_coef[DW-1]}}, w_coef};

`ifdef POLY5_HORNER_SAT_EN
  localparam int SAT_MAX = (2 ** (DW - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DW - 1));

  always_comb begin
    if (w_sum > SAT_MAX)      w_f = {1'b0, {(DW-1){1'b1}}};
    else if (w_sum < SAT_MIN) w_f = {1'b1, {(DW-1){1'b0}}};
    else                      w_f = w_sum[DW-1:0];
  end
`else
  logic w_sum_hi_unused;

  assign w_f             = w_sum[DW-1:0];
  assign w_sum_hi_unused = ^w_sum[2*DW-1:DW];
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_x   <= '0;
      r_acc <= '0;
      r_ret <= '0;
      r_c0  <= '0;
      r_c1  <= '0;
      r_c2  <= '0;
      r_c3  <= '0;
      r_c4  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_x   <= bus.x;
      r_c0  <= bus.c0;
      r_c1  <= bus.c1;
      r_c2  <= bus.c2;
      r_c3  <= bus.c3;
      r_c4  <= bus.c4;
      r_acc <= bus.c5;
      r_cnt <= 3'd4;
    end else if (r_state == S_RUN) begin
      r_acc <= w_f;
      if (r_cnt == 3'd0) r_ret <= w_f;
      else               r_cnt <= r_cnt - 3'd1;
    end
  end

  assign bus.ap_return = r_ret;

endmodule

// File: tb/tb_poly5_horner_ctrl.sv
// Directed and randomized bench for poly5_horner_ctrl (FRAC_BITS=8) with a
// behavioural Horner model and a combinational multiplier on the bus.
module tb_poly5_horner_ctrl;
  localparam int FB = 8;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   total = 0;
  int   bad   = 0;

  poly5_horner_if bus ();

  poly5_horner_ctrl #(.FRAC_BITS(FB), .DW(16)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  logic signed [31:0] mul_a;
  logic signed [31:0] mul_b;
  assign mul_a        = {{16{bus.mul_din0[15]}}, bus.mul_din0};
  assign mul_b        = {{16{bus.mul_din1[15]}}, bus.mul_din1};
  assign bus.mul_dout = mul_a * mul_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  function automatic longint clamp16(input longint s);
`ifdef POLY5_HORNER_SAT_EN
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    logic [15:0] lo;
    lo = s[15:0];
    return longint'($signed(lo));
`endif
  endfunction

  function automatic logic [15:0] ref_eval(input logic [15:0] xv, input logic [15:0] cv [6]);
    longint acc;
    longint p;
    acc = longint'($signed(cv[5]));
    for (int i = 4; i >= 0; i--) begin
      p   = acc * longint'($signed(xv));
      acc = clamp16((p >>> FB) + longint'($signed(cv[i])));
    end
    return acc[15:0];
  endfunction

  task automatic drive_ops(input logic [15:0] xv, input logic [15:0] c [6]);
    bus.x  = xv;
    bus.c0 = c[0];
    bus.c1 = c[1];
    bus.c2 = c[2];
    bus.c3 = c[3];
    bus.c4 = c[4];
    bus.c5 = c[5];
  endtask

  task automatic scramble_ops;
    bus.x  = 16'($urandom);
    bus.c0 = 16'($urandom);
    bus.c1 = 16'($urandom);
    bus.c2 = 16'($urandom);
    bus.c3 = 16'($urandom);
    bus.c4 = 16'($urandom);
    bus.c5 = 16'($urandom);
  endtask

  // Accept in cycle 0, RUN cycles 1..5, ap_done in cycle 6, IDLE in cycle 7.
  task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] c [6],
                        input logic [15:0] exp, input bit scramble);
    drive_ops(xv, c);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    check({tag, ":din0"}, bus.mul_din0, c[5]);
    check({tag, ":din1"}, bus.mul_din1, xv);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      check({tag, ":idle_run"}, bus.ap_idle, 1'b0);
      check({tag, ":done_run"}, bus.ap_done, 1'b0);
      if (scramble) scramble_ops();
      tick();
    end
    check({tag, ":done"}, bus.ap_done, 1'b1);
    check({tag, ":ready"}, bus.ap_ready, 1'b1);
    check({tag, ":idle_done"}, bus.ap_idle, 1'b0);
    check({tag, ":ret"}, bus.ap_return, exp);
    tick();
    check({tag, ":done_after"}, bus.ap_done, 1'b0);
    check({tag, ":idle_after"}, bus.ap_idle, 1'b1);
    check({tag, ":ret_hold"}, bus.ap_return, exp);
  endtask

  logic [15:0] cv  [6];
  logic [15:0] cvb [6];
  logic [15:0] xr;
  logic [15:0] exp3;

  initial begin
    ap_rst       = 1'b1;
    bus.ap_start = 1'b0;
    cv           = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    drive_ops(16'h0, cv);
    tick();
    tick();
    check("rst:idle", bus.ap_idle, 1'b1);
    check("rst:done", bus.ap_done, 1'b0);
    check("rst:ready", bus.ap_ready, 1'b0);
    check("rst:ret", bus.ap_return, 16'h0);
    check("rst:din0", bus.mul_din0, 16'h0);
    check("rst:din1", bus.mul_din1, 16'h0);
    ap_rst = 1'b0;
    tick();

    cv = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_op("t1", 16'h0100, cv, 16'h0600, 1'b0);

    cv = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_op("t2", 16'h0000, cv, 16'h1234, 1'b0);

`ifdef POLY5_HORNER_SAT_EN
    exp3 = 16'h7FFF;
`else
    exp3 = 16'h0000;
`endif
    cv = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000};
    run_op("t3", 16'h0200, cv, exp3, 1'b0);

    // Back-to-back: op B is presented while op A runs and accepted in DONE.
    cv  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    cvb = '{16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    drive_ops(16'h0100, cv);
    bus.ap_start = 1'b1;
    tick();
    drive_ops(16'h0000, cvb);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      check("t4:idle", bus.ap_idle, 1'b0);
      check("t4:done", bus.ap_done, (cyc == 6 || cyc == 12));
      if (cyc == 6)  check("t4:retA", bus.ap_return, 16'h0600);
      if (cyc == 12) begin
        check("t4:retB", bus.ap_return, 16'hFF00);
        bus.ap_start = 1'b0;
      end
      tick();
    end
    check("t4:idle_end", bus.ap_idle, 1'b1);
    check("t4:ret_hold", bus.ap_return, 16'hFF00);

    // Reset asserted during RUN cycle 3.
    drive_ops(16'h0100, cv);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    tick();
    ap_rst = 1'b1;
    tick();
    check("t5:idle", bus.ap_idle, 1'b1);
    check("t5:ret", bus.ap_return, 16'h0);
    check("t5:din0", bus.mul_din0, 16'h0);
    check("t5:done", bus.ap_done, 1'b0);
    ap_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t5:no_done", bus.ap_done, 1'b0);
      check("t5:idle_wait", bus.ap_idle, 1'b1);
    end
    run_op("t5b", 16'h0100, cv, 16'h0600, 1'b0);

    // Reset wins over a simultaneous ap_start.
    bus.ap_start = 1'b1;
    ap_rst       = 1'b1;
    tick();
    check("rw:idle", bus.ap_idle, 1'b1);
    check("rw:din0", bus.mul_din0, 16'h0);
    bus.ap_start = 1'b0;
    ap_rst       = 1'b0;
    tick();
    check("rw:idle2", bus.ap_idle, 1'b1);

    cv = '{16'h0080, 16'hFF40, 16'h0120, 16'h0010, 16'hFFE0, 16'h0050};
    run_op("t6", 16'h0180, cv, ref_eval(16'h0180, cv), 1'b1);

    for (int n = 0; n < 30; n++) begin
      xr = 16'($urandom);
      for (int i = 0; i < 6; i++) cv[i] = 16'($urandom);
      run_op("rnd", xr, cv, ref_eval(xr, cv), n[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
